// File: rtl/cxd2545_sector_sequencer.sv
// Sector-aligned serializer from the drain DMA word stream onto the CXD2545
// BCLK/LRCK/DATA/C2PO pins, with SCOR per sector and sticky error flags.
module cxd2545_sector_sequencer #(
  parameter int WORDS_PER_SECTOR = 1176,
  parameter int BITS_PER_WORD    = 16
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     speed2x,
  input  logic                     tick_2x,
  input  logic [BITS_PER_WORD-1:0] s_data,
  input  logic                     s_sector_start,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     cd_bclk,
  output logic                     cd_lrck,
  output logic                     cd_data,
  output logic                     cd_c2po,
  output logic                     scor,
  output logic [15:0]              sector_count,
  output logic                     underrun,
  output logic                     sync_err,
  input  logic                     clr
);

  localparam int CW  = $clog2(WORDS_PER_SECTOR);
  localparam int BW  = $clog2(BITS_PER_WORD);
  localparam int MSB = BITS_PER_WORD - 1;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t                   state_q, state_d;
  logic                     div_q, div_d, spd_q, spd_d, first_q, first_d, stop_q, stop_d;
  logic                     bclk_q, bclk_d, lrck_q, lrck_d, data_q, data_d;
  logic                     c2po_q, c2po_d, scor_q, scor_d;
  logic                     underrun_q, underrun_d, sync_err_q, sync_err_d;
  logic [BITS_PER_WORD-1:0] shreg_q, shreg_d, word_in;
  logic [BW-1:0]            bit_q, bit_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_next;
  logic [15:0]              sec_q, sec_d;
  logic                     eff;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= 1'b0;
      spd_q      <= 1'b0;
      first_q    <= 1'b0;
      stop_q     <= 1'b0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      data_q     <= 1'b0;
      c2po_q     <= 1'b0;
      scor_q     <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
      shreg_q    <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      sec_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      spd_q      <= spd_d;
      first_q    <= first_d;
      stop_q     <= stop_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      data_q     <= data_d;
      c2po_q     <= c2po_d;
      scor_q     <= scor_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      sec_q      <= sec_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    spd_d      = spd_q;
    first_d    = first_q;
    stop_d     = stop_q;
    bclk_d     = bclk_q;
    lrck_d     = lrck_q;
    data_d     = data_q;
    c2po_d     = c2po_q;
    scor_d     = scor_q;
    underrun_d = underrun_q;
    sync_err_d = sync_err_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    sec_d      = sec_q;
    s_ready    = 1'b0;
    word_in    = '0;
    cnt_next   = '0;
    eff        = tick_2x & (spd_q | div_q);

    // Clear first so that a flag being set in the same cycle wins.
    if (clr) begin
      underrun_d = 1'b0;
      sync_err_d = 1'b0;
    end

    case (state_q)
      IDLE: if (enable) state_d = SYNC;

      SYNC: begin
        s_ready = enable;
        if (!enable) begin
          state_d = IDLE;
        end else if (s_valid && s_sector_start) begin
          state_d = RUN;
          shreg_d = s_data;
          cnt_d   = '0;
          spd_d   = speed2x;
          first_d = 1'b1;
          stop_d  = 1'b0;
          div_d   = 1'b0;
        end
      end

      RUN: begin
        if (tick_2x) div_d = ~div_q;
        if (!enable) stop_d = 1'b1;
        if (eff) begin
          // Word 0 arrives with BCLK already low, so its first edge only drives data.
          if (first_q) begin
            first_d = 1'b0;
            lrck_d  = 1'b1;
            data_d  = shreg_q[MSB];
            shreg_d = shreg_q << 1;
            bit_d   = BW'(BITS_PER_WORD - 1);
            c2po_d  = 1'b0;
            scor_d  = 1'b1;
          end else if (!bclk_q) begin
            bclk_d = 1'b1;
          end else if (bit_q != '0) begin
            bclk_d  = 1'b0;
            data_d  = shreg_q[MSB];
            shreg_d = shreg_q << 1;
            bit_d   = bit_q - 1'b1;
          end else if ((stop_q || !enable) && !lrck_q) begin
            state_d = IDLE;
            bclk_d  = 1'b0;
            lrck_d  = 1'b0;
            data_d  = 1'b0;
            c2po_d  = 1'b0;
            scor_d  = 1'b0;
            div_d   = 1'b0;
            stop_d  = 1'b0;
          end else begin
            s_ready = 1'b1;
            bclk_d  = 1'b0;
            lrck_d  = ~lrck_q;
            if (!lrck_q) spd_d = speed2x;
            cnt_next = (cnt_q == CW'(WORDS_PER_SECTOR - 1)) ? '0 : cnt_q + 1'b1;
            if (cnt_next == '0) sec_d = sec_q + 16'd1;
            if (s_valid) begin
              word_in = s_data;
              c2po_d  = 1'b0;
              if (s_sector_start && cnt_next != '0) begin
                sync_err_d = 1'b1;
                cnt_next   = '0;
                sec_d      = sec_q + 16'd1;
              end else if (cnt_next == '0 && !s_sector_start) begin
                sync_err_d = 1'b1;
              end
            end else begin
              word_in    = '0;
              c2po_d     = 1'b1;
              underrun_d = 1'b1;
            end
            cnt_d   = cnt_next;
            scor_d  = (cnt_next < CW'(2));
            data_d  = word_in[MSB];
            shreg_d = word_in << 1;
            bit_d   = BW'(BITS_PER_WORD - 1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cd_bclk      = bclk_q;
  assign cd_lrck      = lrck_q;
  assign cd_data      = data_q;
  assign cd_c2po      = c2po_q;
  assign scor         = scor_q;
  assign sector_count = sec_q;
  assign underrun     = underrun_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_cxd2545_sector_sequencer.sv
// Randomized scoreboard bench: the driver pushes expected slots as words are
// accepted; an independent monitor deserializes the pins and compares.
module tb_cxd2545_sector_sequencer;

  localparam int WPS = 24;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        speed2x = 1'b0;
  logic        tick_2x = 1'b0;
  logic [15:0] s_data = 16'h0;
  logic        s_sector_start = 1'b0;
  logic        s_valid = 1'b0;
  logic        clr = 1'b0;
  logic        s_ready, cd_bclk, cd_lrck, cd_data, cd_c2po, scor, underrun, sync_err;
  logic [15:0] sector_count;

  cxd2545_sector_sequencer #(.WORDS_PER_SECTOR(WPS), .BITS_PER_WORD(16)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .speed2x(speed2x),
    .tick_2x(tick_2x), .s_data(s_data), .s_sector_start(s_sector_start),
    .s_valid(s_valid), .s_ready(s_ready), .cd_bclk(cd_bclk), .cd_lrck(cd_lrck),
    .cd_data(cd_data), .cd_c2po(cd_c2po), .scor(scor), .sector_count(sector_count),
    .underrun(underrun), .sync_err(sync_err), .clr(clr)
  );

  typedef struct {
    logic [15:0] word;
    logic        lrck;
    logic        c2po;
    logic        scor;
    logic        spd;
  } slot_t;

  slot_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: position in sector, frame half, latched speed, counters.
  bit          m_run = 0, m_stop = 0, m_last_lrck = 0, m_spd = 0, m_ur = 0, m_se = 0;
  int          m_cnt = 0;
  logic [15:0] m_sc = 16'h0;
  int          junk_left = 0, gap_left = 0, inject_pos = -1, run_accepts = 0;
  bit          incr_mode = 0;
  logic [15:0] seq = 16'h0;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    tick_2x = ($urandom_range(3) != 0);
  end

  int tick_cnt = 0;
  always @(posedge sys_clk) if (tick_2x) tick_cnt <= tick_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: shift in DATA on each BCLK rise, hold slot attributes steady.
  int          bitn = 0;
  int          last_tick = 0;
  logic        prev_bclk = 1'b0;
  logic [15:0] shw = 16'h0;
  logic        sl_lrck, sl_c2po, sl_scor, sl_spd;
  slot_t       exp_s;

  always @(negedge sys_clk) begin
    if (!reset_n) begin
      bitn      = 0;
      prev_bclk = 1'b0;
    end else begin
      if (cd_bclk && !prev_bclk) begin
        if (bitn == 0) begin
          sl_lrck = cd_lrck;
          sl_c2po = cd_c2po;
          sl_scor = scor;
          checkOutput("slot_queued", 32'(sb_q.size() != 0), 32'd1);
          sl_spd = (sb_q.size() != 0) ? sb_q[0].spd : 1'b1;
        end else begin
          checkOutput("slot_stable", {29'd0, cd_lrck, cd_c2po, scor}, {29'd0, sl_lrck, sl_c2po, sl_scor});
          checkOutput("bclk_period", 32'(tick_cnt - last_tick), sl_spd ? 32'd2 : 32'd4);
        end
        shw       = {shw[14:0], cd_data};
        last_tick = tick_cnt;
        bitn++;
        if (bitn == 16) begin
          bitn = 0;
          if (sb_q.size() != 0) begin
            exp_s = sb_q.pop_front();
            checkOutput("slot_word", {16'd0, shw}, {16'd0, exp_s.word});
            checkOutput("slot_lrck", {31'd0, sl_lrck}, {31'd0, exp_s.lrck});
            checkOutput("slot_c2po", {31'd0, sl_c2po}, {31'd0, exp_s.c2po});
            checkOutput("slot_scor", {31'd0, sl_scor}, {31'd0, exp_s.scor});
          end
        end
      end
      prev_bclk = cd_bclk;
    end
  end

  task automatic pickNext();
    int pos;
    pos = m_run ? ((m_cnt + 1) % WPS) : 0;
    if (junk_left > 0) begin
      s_valid        = 1'b1;
      s_sector_start = 1'b0;
      s_data         = 16'($urandom);
    end else begin
      s_valid        = (gap_left == 0);
      s_sector_start = (pos == 0) || (pos == inject_pos);
      s_data         = incr_mode ? seq : 16'($urandom);
    end
  endtask

  task automatic modelAccept(input logic acc);
    bit lr;
    int nc;
    if (!m_run) begin
      if (s_valid && s_sector_start) begin
        m_run = 1; m_cnt = 0; m_spd = speed2x; m_last_lrck = 1;
        sb_q.push_back('{s_data, 1'b1, 1'b0, 1'b1, speed2x});
        if (incr_mode) seq++;
      end else if (s_valid && junk_left > 0) begin
        junk_left--;
      end
    end else if (m_stop && !m_last_lrck) begin
      checkOutput("accept_after_stop", {31'd0, acc}, 32'd0);
    end else begin
      lr = !m_last_lrck;
      if (lr) m_spd = speed2x;
      nc = (m_cnt + 1) % WPS;
      if (nc == 0) m_sc++;
      if (s_valid) begin
        if (s_sector_start && nc != 0) begin
          m_se = 1; nc = 0; m_sc++; inject_pos = -1;
        end else if (nc == 0 && !s_sector_start) begin
          m_se = 1;
        end
        sb_q.push_back('{s_data, lr, 1'b0, (nc < 2), m_spd});
        if (incr_mode) seq++;
      end else begin
        m_ur = 1;
        if (gap_left > 0) gap_left--;
        sb_q.push_back('{16'h0, lr, 1'b1, (nc < 2), m_spd});
      end
      m_cnt = nc;
      m_last_lrck = lr;
      run_accepts++;
    end
  endtask

  task automatic step();
    logic acc;
    @(negedge sys_clk);
    checkOutput("sector_count", {16'd0, sector_count}, {16'd0, m_sc});
    checkOutput("flags", {30'd0, underrun, sync_err}, {30'd0, m_ur, m_se});
    acc = s_ready;
    @(posedge sys_clk);
    #1;
    if (clr) begin
      m_ur = 0; m_se = 0; clr = 1'b0;
    end
    if (acc) begin
      modelAccept(acc);
      pickNext();
    end
  endtask

  task automatic applyStimulus(input int n);
    int target, budget;
    target = run_accepts + n;
    budget = n * 120 + 300;
    while (run_accepts < target && budget > 0) begin
      step();
      budget--;
    end
    checkOutput("progress_timeout", 32'(budget > 0), 32'd1);
  endtask

  initial begin
    int budget;
    $display("[TB] start");
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_outputs", {26'd0, s_ready, cd_bclk, cd_lrck, cd_data, cd_c2po, scor}, 32'd0);
    checkOutput("reset_sector_count", {16'd0, sector_count}, 32'd0);
    checkOutput("reset_flags", {30'd0, underrun, sync_err}, 32'd0);
    reset_n = 1'b1;

    // 1x, junk then an incrementing sector starting at 0x8001.
    incr_mode = 1; seq = 16'h8001; junk_left = 3; speed2x = 1'b0;
    pickNext();
    enable = 1'b1;
    applyStimulus(WPS + 4);
    @(negedge sys_clk);
    checkOutput("sector_count_1x", {16'd0, sector_count}, 32'd1);
    @(posedge sys_clk); #1;

    // 2x, two more sectors of random data.
    incr_mode = 0; speed2x = 1'b1;
    applyStimulus(2 * WPS);
    @(negedge sys_clk);
    checkOutput("sector_count_2x", {16'd0, sector_count}, 32'd3);
    checkOutput("no_err_2x", {30'd0, underrun, sync_err}, 32'd0);
    @(posedge sys_clk); #1;

    // Two withheld slots, then clear.
    gap_left = 2;
    pickNext();
    applyStimulus(6);
    @(negedge sys_clk);
    checkOutput("underrun_set", {31'd0, underrun}, 32'd1);
    @(posedge sys_clk); #1;
    clr = 1'b1;
    step(); step();
    checkOutput("underrun_clr", {31'd0, underrun}, 32'd0);

    // Misplaced sector start.
    inject_pos = (m_cnt + 3) % WPS;
    if (inject_pos < 2) inject_pos = 5;
    pickNext();
    applyStimulus(WPS + 2);
    @(negedge sys_clk);
    checkOutput("sync_err_set", {31'd0, sync_err}, 32'd1);
    @(posedge sys_clk); #1;
    clr = 1'b1;
    step(); step();
    checkOutput("sync_err_clr", {31'd0, sync_err}, 32'd0);

    // Random speed toggles and occasional gaps.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(9) == 0) speed2x = ~speed2x;
      if ($urandom_range(19) == 0) begin
        gap_left = 1;
        pickNext();
      end
      applyStimulus(1);
    end

    // Stop after a left word at position 3.
    budget = 5000;
    while (!(m_cnt == 3 && m_last_lrck) && budget > 0) begin
      step();
      budget--;
    end
    checkOutput("reach_word3_timeout", 32'(budget > 0), 32'd1);
    enable = 1'b0;
    m_stop = 1;
    budget = 800;
    while (!(sb_q.size() == 0 && !m_last_lrck) && budget > 0) begin
      step();
      budget--;
    end
    checkOutput("stop_timeout", 32'(budget > 0), 32'd1);
    repeat (30) step();
    checkOutput("idle_outputs", {26'd0, s_ready, cd_bclk, cd_lrck, cd_data, cd_c2po, scor}, 32'd0);
    checkOutput("idle_queue_empty", 32'(sb_q.size()), 32'd0);
    m_run = 0; m_stop = 0;

    // Restart, then reset in the middle of a word.
    junk_left = 0;
    pickNext();
    enable = 1'b1;
    applyStimulus(5);
    budget = 2000;
    while (bitn != 8 && budget > 0) begin
      step();
      budget--;
    end
    checkOutput("midword_timeout", 32'(budget > 0), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_midword_outputs", {26'd0, s_ready, cd_bclk, cd_lrck, cd_data, cd_c2po, scor}, 32'd0);
    checkOutput("reset_midword_count", {16'd0, sector_count}, 32'd0);
    checkOutput("reset_midword_flags", {30'd0, underrun, sync_err}, 32'd0);
    sb_q.delete();
    enable = 1'b0;
    m_run = 0; m_sc = 16'h0; m_ur = 0; m_se = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
